// File: rtl/relu_writeback_if.sv
`default_nettype none
// relu_writeback_if: psum input stream and output-memory write port.
// Revision: 1.0
interface relu_writeback_if #(
  parameter int bw  = 16,
  parameter int col = 8,
  parameter int aw  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [bw*col-1:0] in;
  logic              wr_en;
  logic              wr_ready;
  logic [aw-1:0]     wr_addr;
  logic [bw*col-1:0] wr_data;

  modport slave (
    input  in_valid, in, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/relu_writeback.sv
`default_nettype none
// relu_writeback: accumulates ntap psum beats per pixel, writes ReLU(sum) for npix pixels.
// Revision: 1.0
module relu_writeback #(
  parameter int bw   = 16,
  parameter int col  = 8,
  parameter int ntap = 9,
  parameter int npix = 16,
  parameter int aw   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  relu_writeback_if.slave   bus,
  output logic              busy,
  output logic              done
);
  localparam int TW = (ntap > 1) ? $clog2(ntap) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [bw*col-1:0] acc;
  logic [bw*col-1:0] sum;
  logic [bw*col-1:0] relu;
  logic [bw*col-1:0] wr_data_q;
  logic [TW-1:0]     tap;
  logic [aw-1:0]     pix;
  logic              accept;
  logic              wr_hs;
  logic              last_tap;
  logic              last_pix;

  // Handshakes derived from state directly so they do not depend on the FSM output process.
  assign accept   = (state == ACC) & bus.in_valid;
  assign wr_hs    = (state == WRITE) & bus.wr_ready;
  assign last_tap = (tap == TW'(ntap - 1));
  assign last_pix = (pix == aw'(npix - 1));

  assign bus.wr_addr = pix;
  assign bus.wr_data = wr_data_q;

  for (genvar i = 0; i < col; i++) begin : g_lane
    assign sum[bw*i +: bw]  = acc[bw*i +: bw] + bus.in[bw*i +: bw];
    assign relu[bw*i +: bw] = sum[bw*(i+1)-1] ? '0 : sum[bw*i +: bw];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACC;
      end
      ACC: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && last_tap) state_nxt = WRITE;
      end
      WRITE: begin
        bus.wr_en = 1'b1;
        if (bus.wr_ready) state_nxt = last_pix ? DONE : ACC;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      tap       <= '0;
      pix       <= '0;
      wr_data_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc <= '0;
        tap <= '0;
        pix <= '0;
      end
      if (accept) begin
        acc <= sum;
        if (last_tap) begin
          tap       <= '0;
          wr_data_q <= relu;
        end else begin
          tap <= tap + 1'b1;
        end
      end
      if (wr_hs) begin
        acc <= '0;
        if (!last_pix) pix <= pix + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire
